// File: rtl/aes_core_arbiter.sv
// Two-requester arbiter sharing one masked AES-128 core; routes results back to the owner.
// Build option: AES_ARB_ROUND_ROBIN_EN (undefined = fixed priority, requester 0 wins ties).
module aes_core_arbiter #(
   parameter int unsigned D = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_req0_valid,
   output logic               o_req0_ready,
   input  logic [128*D-1:0]   i_req0_sh_plaintext,
   input  logic [128*D-1:0]   i_req0_sh_key,
   output logic               o_req0_cipher_valid,
   input  logic               i_req0_out_ready,
   output logic [128*D-1:0]   o_req0_sh_ciphertext,
   input  logic               i_req1_valid,
   output logic               o_req1_ready,
   input  logic [128*D-1:0]   i_req1_sh_plaintext,
   input  logic [128*D-1:0]   i_req1_sh_key,
   output logic               o_req1_cipher_valid,
   input  logic               i_req1_out_ready,
   output logic [128*D-1:0]   o_req1_sh_ciphertext,
   output logic               o_core_valid_in,
   input  logic               i_core_in_ready,
   output logic [128*D-1:0]   o_core_sh_plaintext,
   output logic [128*D-1:0]   o_core_sh_key,
   input  logic               i_core_cipher_valid,
   output logic               o_core_out_ready,
   input  logic [128*D-1:0]   i_core_sh_ciphertext,
   output logic               o_owner,
   output logic               o_busy,
   output logic [7:0]         o_last_latency
);

   typedef enum logic {StIdle, StRun} state_t;

   state_t      r_state;
   logic        r_owner;
   logic [7:0]  r_lat_cnt;
   logic [7:0]  r_last_latency;

   logic w_prio;
   logic w_idle;
   logic w_run;
   logic w_any;
   logic w_grant;
   logic w_accept;
   logic w_drop;

`ifdef AES_ARB_ROUND_ROBIN_EN
   logic r_prio;
   assign w_prio = r_prio;
`else
   assign w_prio = 1'b0;
`endif

   always_comb begin
      w_idle   = (r_state == StIdle);
      w_run    = (r_state == StRun);
      w_any    = i_req0_valid | i_req1_valid;
      // Priority holder wins when valid, otherwise the other side takes it.
      w_grant  = w_prio ? i_req1_valid : ~i_req0_valid;

      o_core_valid_in     = w_idle & w_any;
      o_core_sh_plaintext = '0;
      o_core_sh_key       = '0;
      if (o_core_valid_in) begin
         o_core_sh_plaintext = w_grant ? i_req1_sh_plaintext : i_req0_sh_plaintext;
         o_core_sh_key       = w_grant ? i_req1_sh_key       : i_req0_sh_key;
      end
      o_req0_ready = o_core_valid_in & i_core_in_ready & ~w_grant;
      o_req1_ready = o_core_valid_in & i_core_in_ready &  w_grant;
      w_accept     = o_core_valid_in & i_core_in_ready;

      o_req0_cipher_valid  = w_run & i_core_cipher_valid & ~r_owner;
      o_req1_cipher_valid  = w_run & i_core_cipher_valid &  r_owner;
      o_core_out_ready     = w_run & (r_owner ? i_req1_out_ready : i_req0_out_ready);
      o_req0_sh_ciphertext = o_req0_cipher_valid ? i_core_sh_ciphertext : '0;
      o_req1_sh_ciphertext = o_req1_cipher_valid ? i_core_sh_ciphertext : '0;
      w_drop               = w_run & i_core_cipher_valid & o_core_out_ready;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= StIdle;
         r_owner        <= 1'b0;
         r_lat_cnt      <= 8'd0;
         r_last_latency <= 8'd0;
`ifdef AES_ARB_ROUND_ROBIN_EN
         r_prio         <= 1'b0;
`endif
      end else begin
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_owner   <= w_grant;
                  r_lat_cnt <= 8'd1;
                  r_state   <= StRun;
               end
            end
            StRun: begin
               if (r_lat_cnt != 8'hFF) begin
                  r_lat_cnt <= r_lat_cnt + 8'd1;
               end
               if (w_drop) begin
                  r_last_latency <= r_lat_cnt;
                  r_state        <= StIdle;
`ifdef AES_ARB_ROUND_ROBIN_EN
                  r_prio         <= ~r_owner;
`endif
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_owner        = r_owner;
   assign o_busy         = w_run;
   assign o_last_latency = r_last_latency;

endmodule

// File: doc/aes_core_arbiter.md
# aes_core_arbiter

Two-requester round-robin arbiter that shares one masked AES-128 encryption core (32-bit masked core with valid_in/in_ready/cipher_valid/out_ready handshake) between two clients. It sits between the clients and the core:
- selects one request at a time and forwards its masked plaintext/key sharings;
- tracks the owner of the in-flight encryption and routes the ciphertext and output handshake back to that owner only;
- drives all-zero sharings to every port that is not currently entitled to data.

## Interface
- d, 2, masking order (shares per bit); all sharings are bit-compact, 128*d bits.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  (N=0,1) request N presents plaintext/key.
- reqN_ready  out  1  request N accepted this cycle.
- reqN_sh_plaintext, reqN_sh_key  in  128*d  masked inputs of request N; stable while reqN_valid=1.
- reqN_cipher_valid  out  1  ciphertext for request N available.
- reqN_out_ready  in  1  request N fetches ciphertext.
- reqN_sh_ciphertext  out  128*d  ciphertext sharing; all zeros unless reqN_cipher_valid=1.
- core_valid_in  out  1  to core valid_in.
- core_in_ready  in  1  from core in_ready.
- core_sh_plaintext, core_sh_key  out  128*d  to core; all zeros unless core_valid_in=1.
- core_cipher_valid  in  1  from core cipher_valid.
- core_out_ready  out  1  to core out_ready.
- core_sh_ciphertext  in  128*d  from core.
- owner  out  1  index of requester owning the in-flight operation.
- busy  out  1  1 while state is RUN.
- last_latency  out  8  cycles from acceptance to result drop of the last operation, saturating at 255.

## Operation
- FSM states: IDLE, RUN. Registers: state, prio (1 bit), owner (1 bit), lat_cnt (8 bits), last_latency (8 bits).
- Grant (combinational, IDLE only):
  - grant = prio when req[prio]_valid; otherwise the other requester when its valid is set.
  - No grant when neither requester is valid.
- IDLE:
  - core_valid_in = any reqN_valid.
  - core_sh_plaintext/key = sharings of the granted requester, zeros otherwise.
  - reqN_ready = core_in_ready & core_valid_in & (grant==N).
  - On an accept edge (core_valid_in & core_in_ready): owner <= grant, lat_cnt <= 1, state <= RUN.
- RUN:
  - core_valid_in = 0; all reqN_ready = 0; core input sharings are zero.
  - lat_cnt increments each cycle, saturating at 255.
  - reqN_cipher_valid = core_cipher_valid & (owner==N).
  - core_out_ready = req[owner]_out_ready.
  - reqN_sh_ciphertext = core_sh_ciphertext when reqN_cipher_valid, zeros otherwise. The non-owner always sees zeros.
  - Drop edge (core_cipher_valid & core_out_ready): last_latency <= lat_cnt, prio <= ~owner (round-robin), state <= IDLE.
- The non-owner's out_ready is ignored. core_out_ready is 0 in IDLE.
- Simultaneous valid on both requesters: prio wins; the loser is served next because prio flips after the drop.
- Reset mid-operation: state <= IDLE, prio <= 0, owner <= 0, lat_cnt <= 0, last_latency <= 0. Any in-flight result is discarded.
- The core's own reset is driven by the integration from the same source, so the core and the arbiter restart together.

## Timing
- Reset values: busy=0, owner=0, last_latency=0. Combinational outputs follow the IDLE equations with no grant: core_valid_in=0, core_out_ready=0, all reqN_ready=0, all reqN_cipher_valid=0, all sharings zero.
- Zero-cycle forwarding: accept and drop handshakes pass combinationally through the arbiter.
- The earliest next accept is the cycle after a drop (one IDLE cycle minimum between operations).
- The arbiter never raises core_valid_in while a ciphertext is held. This prevents the core from overwriting an unfetched result.
- last_latency updates on the drop edge and is visible the next cycle.

## Configuration
- AES_ARB_ROUND_ROBIN_EN
  - Defined: round-robin as described above.
  - Undefined: fixed priority. prio is tied to 0 and never updates, so requester 0 always wins simultaneous requests. Everything else is identical.

## Test plan
- Single request: req0_valid=1 with plaintext 00112233445566778899aabbccddeeff and key 000102030405060708090a0b0c0d0e0f (random masks, d=2).
  - req0_ready pulses once; owner=0; busy=1.
  - Unmasked req0_sh_ciphertext = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - req1_sh_ciphertext = 0 throughout.
- Contention: req0 and req1 both valid in the same cycle from reset.
  - req0 is served first, then req1.
  - Repeated contention alternates 0,1,0,1 (macro defined) or stays 0,0,0 (macro undefined).
- Output backpressure: hold req1_out_ready=0 for 20 cycles after req1_cipher_valid rises, with req0_valid=1.
  - req0_ready stays 0 and the ciphertext stays stable.
  - req0 is accepted exactly one cycle after the drop.
- Gating: check every cycle that core_sh_plaintext/key are zero whenever core_valid_in=0, and that reqN_sh_ciphertext is zero whenever reqN_cipher_valid=0.
- Reset mid-RUN: assert rst=0 fifty cycles after an accept.
  - busy=0 and owner=0 immediately; no reqN_cipher_valid follows.
  - A fresh request then completes correctly.
- Latency: stall out_ready for 200 cycles.
  - last_latency = 255 (saturated).
  - With immediate out_ready, last_latency equals the measured core latency.
